// File: rtl/jk_bank_arbiter.sv
// ----------------------------------------------------------------------------
// jk_bank_arbiter
//
// Round-robin arbiter that shares one WIDTH-bit bank of JK flip-flops between
// NUM_REQ requesters. The granted requester's J/K masks are applied per bit
// (00 hold, 01 clear, 10 set, 11 toggle). Every transfer yields a registered
// one-cycle response that carries the requester id and the updated bank.
//
// Optional feature (build macro TFF_ARB_LOCK_EN):
//   A transfer with req_lock=1 locks the grant to that requester until it
//   transfers with req_lock=0. The lock is force-released after LOCK_MAX
//   consecutive cycles in which the owner does not assert req_valid.
//   Without the macro, req_lock is ignored and no lock state is built.
//
// Ports:
//   clk         in   clock, all logic on posedge
//   reset       in   synchronous, active-high reset
//   req_valid   in   [NUM_REQ]        request valid per requester
//   req_j       in   [NUM_REQ*WIDTH]  J masks, requester i at [i*WIDTH +: WIDTH]
//   req_k       in   [NUM_REQ*WIDTH]  K masks, same packing as req_j
//   req_lock    in   [NUM_REQ]        hold grant after this transfer
//   req_ready   out  [NUM_REQ]        one-hot grant, combinational
//   resp_valid  out  1                response strobe, one cycle per transfer
//   resp_id     out  [clog2(NUM_REQ)] id of the requester whose op completed
//   q           out  [WIDTH]          current bank state
// ----------------------------------------------------------------------------
module jk_bank_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int WIDTH    = 8,
    parameter int LOCK_MAX = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_j,
    input  logic [NUM_REQ*WIDTH-1:0]   req_k,
    input  logic [NUM_REQ-1:0]         req_lock,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       resp_valid,
    output logic [$clog2(NUM_REQ)-1:0] resp_id,
    output logic [WIDTH-1:0]           q
);

    localparam int IDW = $clog2(NUM_REQ);

    // Per-bit JK next state: Q+ = J&~Q | ~K&Q
    function automatic logic [WIDTH-1:0] jk_apply(input logic [WIDTH-1:0] cur,
                                                  input logic [WIDTH-1:0] j,
                                                  input logic [WIDTH-1:0] k);
        return (j & ~cur) | (~k & cur);
    endfunction

    logic [IDW-1:0]     last_gnt_q, last_gnt_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               resp_valid_q, resp_valid_d;
    logic [IDW-1:0]     resp_id_q, resp_id_d;

    logic               rr_found;
    logic [IDW-1:0]     rr_idx;
    logic [IDW-1:0]     gnt_idx;
    logic               xfer;
    logic [NUM_REQ-1:0] ready_c;
    logic [WIDTH-1:0]   j_sel, k_sel;

    // ------------------------------------------------------------------------
    // Round-robin search: first valid requester after last_gnt, wrapping.
    // ------------------------------------------------------------------------
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            int cand;
            cand = int'(last_gnt_q) + off;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!rr_found && req_valid[cand[IDW-1:0]]) begin
                rr_found = 1'b1;
                rr_idx   = IDW'(cand);
            end
        end
    end

`ifdef TFF_ARB_LOCK_EN
    localparam int IDLE_W = $clog2(LOCK_MAX + 1);

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [IDW-1:0]      owner_q, owner_d;
    logic [IDLE_W-1:0]   idle_q, idle_d;
    logic                lock_sel;

    // While locked only the owner may be granted, and only when it is valid.
    always_comb begin
        ready_c = '0;
        gnt_idx = rr_idx;
        xfer    = 1'b0;
        if (state_q == LOCK) begin
            gnt_idx = owner_q;
            if (!reset) begin
                ready_c[owner_q] = req_valid[owner_q];
                xfer             = req_valid[owner_q];
            end
        end else if (!reset && rr_found) begin
            ready_c[rr_idx] = 1'b1;
            xfer            = 1'b1;
        end
    end

    assign lock_sel = req_lock[gnt_idx];
`else
    logic unused_lock;
    localparam int unused_lock_max = LOCK_MAX;

    assign unused_lock = ^req_lock;

    always_comb begin
        ready_c = '0;
        gnt_idx = rr_idx;
        xfer    = 1'b0;
        if (!reset && rr_found) begin
            ready_c[rr_idx] = 1'b1;
            xfer            = 1'b1;
        end
    end
`endif

    assign j_sel = req_j[int'(gnt_idx)*WIDTH +: WIDTH];
    assign k_sel = req_k[int'(gnt_idx)*WIDTH +: WIDTH];

    // ------------------------------------------------------------------------
    // Next-state: bank update, response, pointer and (optional) lock FSM.
    // ------------------------------------------------------------------------
    always_comb begin
        last_gnt_d   = last_gnt_q;
        q_d          = q_q;
        resp_valid_d = xfer;
        resp_id_d    = resp_id_q;
        if (xfer) begin
            last_gnt_d = gnt_idx;
            q_d        = jk_apply(q_q, j_sel, k_sel);
            resp_id_d  = gnt_idx;
        end
`ifdef TFF_ARB_LOCK_EN
        state_d = state_q;
        owner_d = owner_q;
        idle_d  = idle_q;
        case (state_q)
            ARB: begin
                if (xfer && lock_sel) begin
                    state_d = LOCK;
                    owner_d = gnt_idx;
                    idle_d  = '0;
                end
            end
            LOCK: begin
                if (xfer) begin
                    idle_d = '0;
                    if (!lock_sel) state_d = ARB;
                end else if (idle_q == IDLE_W'(LOCK_MAX - 1)) begin
                    // This idle cycle brings the count to LOCK_MAX: release.
                    state_d    = ARB;
                    last_gnt_d = owner_q;
                    idle_d     = '0;
                end else begin
                    idle_d = idle_q + IDLE_W'(1);
                end
            end
            default: state_d = ARB;
        endcase
`endif
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            last_gnt_q   <= IDW'(NUM_REQ - 1);
            q_q          <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
        end else begin
            last_gnt_q   <= last_gnt_d;
            q_q          <= q_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
        end
    end

`ifdef TFF_ARB_LOCK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB;
            owner_q <= '0;
            idle_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            idle_q  <= idle_d;
        end
    end
`endif

    assign req_ready  = ready_c;
    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign q          = q_q;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// ----------------------------------------------------------------------------
// tb_jk_bank_arbiter
//
// Directed bench for jk_bank_arbiter (NUM_REQ=4, WIDTH=8). Lock scenarios are
// built only when TFF_ARB_LOCK_EN is defined; otherwise a check that req_lock
// is ignored runs instead.
// ----------------------------------------------------------------------------
module tb_jk_bank_arbiter;

    localparam int NR = 4;
    localparam int W  = 8;

    logic            clk;
    logic            reset;
    logic [NR-1:0]   req_valid;
    logic [NR*W-1:0] req_j;
    logic [NR*W-1:0] req_k;
    logic [NR-1:0]   req_lock;
    logic [NR-1:0]   req_ready;
    logic            resp_valid;
    logic [1:0]      resp_id;
    logic [W-1:0]    q;

    int n_chk  = 0;
    int n_fail = 0;

    jk_bank_arbiter #(.NUM_REQ(NR), .WIDTH(W), .LOCK_MAX(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_j      (req_j),
        .req_k      (req_k),
        .req_lock   (req_lock),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .q          (q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_jk(input int i, input logic [W-1:0] j, input logic [W-1:0] k);
        req_j[i*W +: W] = j;
        req_k[i*W +: W] = k;
    endtask

    initial begin
        logic [W-1:0] exp_q;

        reset     = 1'b1;
        req_valid = 4'b1111;
        req_j     = '0;
        req_k     = '0;
        req_lock  = '0;

        // Test 1: reset held 3 cycles with every requester valid.
        for (int c = 0; c < 3; c++) begin
            step();
            #1;
            chk("rst_ready", 32'(req_ready), 32'h0);
            chk("rst_q", 32'(q), 32'h00);
            chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        end
        chk("rst_resp_id", 32'(resp_id), 32'h0);

        // Release; first grant goes to requester 0.
        reset = 1'b0;
        #1;
        chk("first_grant", 32'(req_ready), 32'b0001);

        // Test 2: sequential ops on requester 0 (set, toggle, clear).
        req_valid = 4'b0001;
        set_jk(0, 8'h0F, 8'h00);
        #1;
        chk("t2_ready_a", 32'(req_ready), 32'b0001);
        step();
        set_jk(0, 8'hFF, 8'hFF);
        #1;
        chk("t2_resp_valid_a", 32'(resp_valid), 32'h1);
        chk("t2_resp_id_a", 32'(resp_id), 32'h0);
        chk("t2_q_set", 32'(q), 32'h0F);
        chk("t2_ready_b", 32'(req_ready), 32'b0001);
        step();
        set_jk(0, 8'h00, 8'h30);
        #1;
        chk("t2_q_toggle", 32'(q), 32'hF0);
        chk("t2_resp_valid_b", 32'(resp_valid), 32'h1);
        step();
        req_valid = 4'b0000;
        #1;
        chk("t2_q_clear", 32'(q), 32'hC0);
        chk("t2_resp_valid_c", 32'(resp_valid), 32'h1);
        chk("idle_ready", 32'(req_ready), 32'h0);
        step();
        #1;
        chk("idle_resp_valid", 32'(resp_valid), 32'h0);
        chk("idle_q_hold", 32'(q), 32'hC0);
        chk("idle_ready_b", 32'(req_ready), 32'h0);

        // Test 3: fresh reset, then all four valid toggling bit 0.
        reset = 1'b1;
        step();
        reset = 1'b0;
        req_valid = 4'b1111;
        for (int i = 0; i < NR; i++) set_jk(i, 8'h01, 8'h01);
        exp_q = 8'h00;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) step();
            #1;
            chk("t3_grant", 32'(req_ready), 32'(1 << (c % 4)));
            chk("t3_q", 32'(q), 32'(exp_q));
            if (c > 0) begin
                chk("t3_resp_valid", 32'(resp_valid), 32'h1);
                chk("t3_resp_id", 32'(resp_id), 32'((c - 1) % 4));
            end
            exp_q = exp_q ^ 8'h01;
        end
        step();
        req_valid = 4'b0000;
        #1;
        chk("t3_resp_id_last", 32'(resp_id), 32'h1);
        chk("t3_q_last", 32'(q), 32'(exp_q));
        chk("t3_ready_off", 32'(req_ready), 32'h0);

`ifdef TFF_ARB_LOCK_EN
        // Test 4: requester 1 locks while 0 and 2 are also valid.
        reset = 1'b1;
        step();
        reset = 1'b0;
        req_valid = 4'b0010;
        req_lock  = 4'b0010;
        set_jk(1, 8'h01, 8'h01);
        #1;
        chk("t4_lock_grant", 32'(req_ready), 32'b0010);
        for (int c = 0; c < 3; c++) begin
            step();
            req_valid = 4'b0111;
            #1;
            chk("t4_locked_grant", 32'(req_ready), 32'b0010);
        end
        step();
        req_lock = 4'b0000;
        #1;
        chk("t4_unlock_grant", 32'(req_ready), 32'b0010);
        step();
        req_valid = 4'b0101;
        #1;
        chk("t4_after_unlock_a", 32'(req_ready), 32'b0100);
        step();
        #1;
        chk("t4_after_unlock_b", 32'(req_ready), 32'b0001);

        // Test 5: owner goes idle; lock force-released after 16 cycles.
        reset = 1'b1;
        step();
        reset = 1'b0;
        req_valid = 4'b0010;
        req_lock  = 4'b0010;
        #1;
        chk("t5_lock_grant", 32'(req_ready), 32'b0010);
        for (int c = 1; c <= 16; c++) begin
            step();
            req_valid = 4'b0001;
            req_lock  = 4'b0000;
            #1;
            chk("t5_held", 32'(req_ready), 32'h0);
        end
        step();
        #1;
        chk("t5_release_grant", 32'(req_ready), 32'b0001);

        // Test 6: reset while locked with q=0x5A.
        reset = 1'b1;
        step();
        reset = 1'b0;
        req_valid = 4'b0010;
        req_lock  = 4'b0010;
        set_jk(1, 8'h5A, 8'hA5);
        #1;
        chk("t6_lock_grant", 32'(req_ready), 32'b0010);
        step();
        set_jk(1, 8'h00, 8'h00);
        #1;
        chk("t6_q_locked", 32'(q), 32'h5A);
        reset = 1'b1;
        #1;
        chk("t6_ready_in_reset", 32'(req_ready), 32'h0);
        step();
        reset = 1'b0;
        req_valid = 4'b1111;
        req_lock  = 4'b0000;
        #1;
        chk("t6_q_cleared", 32'(q), 32'h00);
        chk("t6_resp_valid", 32'(resp_valid), 32'h0);
        chk("t6_first_grant", 32'(req_ready), 32'b0001);
`else
        // Without the lock feature req_lock has no effect on arbitration.
        reset = 1'b1;
        step();
        reset = 1'b0;
        req_valid = 4'b0010;
        req_lock  = 4'b0010;
        set_jk(1, 8'h80, 8'h00);
        #1;
        chk("nolock_grant", 32'(req_ready), 32'b0010);
        step();
        req_valid = 4'b0001;
        #1;
        chk("nolock_other_grant", 32'(req_ready), 32'b0001);
        chk("nolock_q", 32'(q), 32'h80);
        chk("nolock_resp_id", 32'(resp_id), 32'h1);
`endif

        req_valid = '0;
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
